// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative IEEE-754 multiplier with valid/ready handshakes, four rounding modes and exception flags.
// Optional FP_MUL_FTZ_EN: subnormal inputs and tiny results are flushed to signed zero.
module fp_mul_seq #(
   parameter int NEXP = 11,
   parameter int NSIG = 52
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NEXP+NSIG:0]   a,
   input  logic [NEXP+NSIG:0]   b,
   input  logic [1:0]           rm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NEXP+NSIG:0]   p,
   output logic                 nan,
   output logic                 inf,
   output logic                 zero,
   output logic                 dnorm,
   output logic                 norm,
   output logic                 invalid,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact
);
   localparam int W  = NEXP + NSIG + 1;
   localparam int M  = NSIG + 1;
   localparam int PW = 2 * M;
   localparam int EW = NEXP + $clog2(PW) + 3;
   localparam int CW = $clog2(M);
   localparam logic [NEXP-1:0] EMAX = '1;
   localparam logic [NEXP-1:0] EMAX1 = EMAX - 1'b1;
   localparam logic signed [EW-1:0] BIAS = EW'((1 << (NEXP - 1)) - 1);
   localparam logic signed [EW-1:0] EMAXS = EW'((1 << NEXP) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(NSIG - 1){1'b0}}};

   typedef enum logic [2:0] {IDLE, UNPK, MUL, RND, DONE} state_t;

   state_t                 state_q;
   logic [W-1:0]           a_q, b_q, p_q, spec_p_q;
   logic [1:0]             rm_q;
   logic                   sign_q, spec_q, spec_inv_q, in_ready_q, out_valid_q;
   logic signed [EW-1:0]   exp_q;
   logic [PW-1:0]          mcand_q, prod_q;
   logic [M-1:0]           mb_q;
   logic [CW-1:0]          cnt_q;
   logic [4:0]             cls_q;
   logic [3:0]             flg_q;

   function automatic logic [4:0] classify(input logic [W-1:0] x);
      logic ez, eo, fz;
      ez = ~|x[W-2:NSIG];
      eo = &x[W-2:NSIG];
      fz = ~|x[NSIG-1:0];
      return {eo & ~fz, eo & fz, ez & fz, ez & ~fz, ~ez & ~eo};
   endfunction

   logic                   eza, ezb, eoa, eob, fza, fzb, na, nb, ia, ib, za, zb, s, u_spec, u_inv, u_nan;
   logic [NEXP-1:0]        eea, eeb;
   logic [W-1:0]           u_p;
   logic signed [EW-1:0]   exp_sum;

   always_comb begin
      eza = ~|a_q[W-2:NSIG];
      ezb = ~|b_q[W-2:NSIG];
      eoa = &a_q[W-2:NSIG];
      eob = &b_q[W-2:NSIG];
      fza = ~|a_q[NSIG-1:0];
      fzb = ~|b_q[NSIG-1:0];
      na = eoa & ~fza;
      nb = eob & ~fzb;
      ia = eoa & fza;
      ib = eob & fzb;
`ifdef FP_MUL_FTZ_EN
      za = eza;
      zb = ezb;
`else
      za = eza & fza;
      zb = ezb & fzb;
`endif
      s = a_q[W-1] ^ b_q[W-1];
      u_nan = na | nb | (ia & zb) | (za & ib);
      u_inv = (ia & zb) | (za & ib) | (na & ~a_q[NSIG-1]) | (nb & ~b_q[NSIG-1]);
      u_spec = u_nan | ia | ib | za | zb;
      u_p = u_nan ? QNAN : (ia | ib) ? {s, EMAX, {NSIG{1'b0}}} : {s, {(W - 1){1'b0}}};
      // subnormals carry a zero hidden bit at the minimum exponent of 1
      eea = eza ? NEXP'(1) : a_q[W-2:NSIG];
      eeb = ezb ? NEXP'(1) : b_q[W-2:NSIG];
      exp_sum = EW'(eea) + EW'(eeb) - BIAS;
   end

   logic signed [EW-1:0]   lz, en;
   logic [EW-1:0]          sh;
   logic [PW-1:0]          pn, pd;
   logic [NEXP-1:0]        field;
   logic [NEXP+NSIG-1:0]   rnd;
   logic                   tiny, g, st, inc, ix, ovf, huge;
   logic [W-1:0]           r_p;
   logic [3:0]             r_f;

   always_comb begin
      lz = '0;
      for (int i = 0; i < PW; i++)
         if (prod_q[i]) lz = EW'(PW - 1 - i);
      pn = prod_q << lz;
      en = exp_q + EW'(1) - lz;
      tiny = en < 1;
      sh = tiny ? EW'(1 - en) : '0;
      pd = pn >> sh;
      g = pd[NSIG];
      st = (|pd[NSIG-1:0]) | ((pd << sh) != pn);
      ix = g | st;
      inc = (rm_q == 2'd0) ? g & (st | pd[NSIG+1]) :
            (rm_q == 2'd1) ? 1'b0 :
            (rm_q == 2'd2) ? ~sign_q & ix : sign_q & ix;
      field = tiny ? '0 : en[NEXP-1:0];
      // carry out of the fraction ripples straight into the exponent field
      rnd = {field, pd[PW-2 -: NSIG]} + {{(NEXP + NSIG - 1){1'b0}}, inc};
      ovf = (en >= EMAXS) | (&rnd[NEXP+NSIG-1:NSIG]);
      huge = (rm_q == 2'd0) | ((rm_q == 2'd2) & ~sign_q) | ((rm_q == 2'd3) & sign_q);
      r_p = ovf ? (huge ? {sign_q, EMAX, {NSIG{1'b0}}} : {sign_q, EMAX1, {NSIG{1'b1}}}) : {sign_q, rnd};
      r_f = ovf ? 4'b0101 : {2'b00, ~|rnd[NEXP+NSIG-1:NSIG] & ix, ix};
`ifdef FP_MUL_FTZ_EN
      if (tiny) begin
         r_p = {sign_q, {(W - 1){1'b0}}};
         r_f = 4'b0011;
      end
`endif
      if (spec_q) begin
         r_p = spec_p_q;
         r_f = {spec_inv_q, 3'b000};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         p_q <= '0;
         cls_q <= 5'b00100;
         flg_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q <= a;
               b_q <= b;
               rm_q <= rm;
               in_ready_q <= 1'b0;
               state_q <= UNPK;
            end
            UNPK: begin
               sign_q <= s;
               exp_q <= exp_sum;
               mcand_q <= PW'({~eza, a_q[NSIG-1:0]});
               mb_q <= {~ezb, b_q[NSIG-1:0]};
               prod_q <= '0;
               cnt_q <= '0;
               spec_q <= u_spec;
               spec_p_q <= u_p;
               spec_inv_q <= u_inv;
               state_q <= u_spec ? RND : MUL;
            end
            MUL: begin
               prod_q <= prod_q + (mb_q[0] ? mcand_q : '0);
               mcand_q <= mcand_q << 1;
               mb_q <= mb_q >> 1;
               cnt_q <= cnt_q + 1'b1;
               state_q <= (cnt_q == CW'(NSIG)) ? RND : MUL;
            end
            RND: begin
               p_q <= r_p;
               cls_q <= classify(r_p);
               flg_q <= r_f;
               out_valid_q <= 1'b1;
               state_q <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign out_valid = out_valid_q;
   assign p = p_q;
   assign {nan, inf, zero, dnorm, norm} = cls_q;
   assign {invalid, overflow, underflow, inexact} = flg_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed double-precision vectors with hand-computed products, flags and latencies,
// plus backpressure and mid-operation reset scenarios.
module tb_fp_mul_seq;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] a, b, p;
   logic [1:0]  rm;
   logic        nan, inf, zero, dnorm, norm, invalid, overflow, underflow, inexact;
   int          n_cmp = 0, n_bad = 0;

   fp_mul_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .rm(rm),
      .out_valid(out_valid), .out_ready(out_ready), .p(p),
      .nan(nan), .inf(inf), .zero(zero), .dnorm(dnorm), .norm(norm),
      .invalid(invalid), .overflow(overflow), .underflow(underflow), .inexact(inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a, b;
      logic [1:0]  rm;
      logic [63:0] p;
      logic [4:0]  c;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input int idx, input vec_t t);
      int n;
      a = t.a;
      b = t.b;
      rm = t.rm;
      in_valid = 1'b1;
      chk($sformatf("v%0d.in_ready", idx), 80'(in_ready), 80'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk($sformatf("v%0d.latency", idx), 80'(n), 80'(t.lat));
      chk($sformatf("v%0d.p", idx), 80'(p), 80'(t.p));
      chk($sformatf("v%0d.class", idx), 80'({nan, inf, zero, dnorm, norm}), 80'(t.c));
      chk($sformatf("v%0d.flags", idx), 80'({invalid, overflow, underflow, inexact}), 80'(t.f));
      @(posedge clk);
      #1 chk($sformatf("v%0d.release", idx), 80'({out_valid, in_ready}), 80'(2'b01));
   endtask

   initial begin
      int n, stale;
      // class {nan,inf,zero,dnorm,norm}, flags {invalid,overflow,underflow,inexact}
      vq.push_back('{64'h3FF8000000000000, 64'h4000000000000000, 2'd0, 64'h4008000000000000, 5'b00001, 4'b0000, 55});
      vq.push_back('{64'h7FF0000000000000, 64'h0000000000000000, 2'd0, 64'h7FF8000000000000, 5'b10000, 4'b1000, 2});
      vq.push_back('{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd0, 64'h7FF0000000000000, 5'b01000, 4'b0101, 55});
      vq.push_back('{64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd1, 64'h7FEFFFFFFFFFFFFF, 5'b00001, 4'b0101, 55});
      vq.push_back('{64'h8000000000000000, 64'h3FF0000000000000, 2'd0, 64'h8000000000000000, 5'b00100, 4'b0000, 2});
      vq.push_back('{64'h7FF0000000000001, 64'h3FF0000000000000, 2'd0, 64'h7FF8000000000000, 5'b10000, 4'b1000, 2});
      vq.push_back('{64'h7FF8000000000000, 64'h3FF0000000000000, 2'd0, 64'h7FF8000000000000, 5'b10000, 4'b0000, 2});
      vq.push_back('{64'h7FF0000000000000, 64'hC000000000000000, 2'd0, 64'hFFF0000000000000, 5'b01000, 4'b0000, 2});
      vq.push_back('{64'h3FF0000000000001, 64'h3FF0000000000001, 2'd0, 64'h3FF0000000000002, 5'b00001, 4'b0001, 55});
      vq.push_back('{64'h3FF0000000000001, 64'h3FF0000000000001, 2'd2, 64'h3FF0000000000003, 5'b00001, 4'b0001, 55});
      vq.push_back('{64'hBFF0000000000001, 64'h3FF0000000000001, 2'd3, 64'hBFF0000000000003, 5'b00001, 4'b0001, 55});
      vq.push_back('{64'hBFF0000000000001, 64'h3FF0000000000001, 2'd1, 64'hBFF0000000000002, 5'b00001, 4'b0001, 55});
      vq.push_back('{64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd2, 64'hFFEFFFFFFFFFFFFF, 5'b00001, 4'b0101, 55});
      vq.push_back('{64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 2'd3, 64'hFFF0000000000000, 5'b01000, 4'b0101, 55});
`ifdef FP_MUL_FTZ_EN
      vq.push_back('{64'h0010000000000000, 64'h3FE0000000000000, 2'd0, 64'h0000000000000000, 5'b00100, 4'b0011, 55});
      vq.push_back('{64'h0000000000000001, 64'h3FE0000000000000, 2'd0, 64'h0000000000000000, 5'b00100, 4'b0000, 2});
      vq.push_back('{64'h0000000000000001, 64'h3FE0000000000000, 2'd2, 64'h0000000000000000, 5'b00100, 4'b0000, 2});
      vq.push_back('{64'h0008000000000000, 64'h4000000000000000, 2'd0, 64'h0000000000000000, 5'b00100, 4'b0000, 2});
`else
      vq.push_back('{64'h0010000000000000, 64'h3FE0000000000000, 2'd0, 64'h0008000000000000, 5'b00010, 4'b0000, 55});
      vq.push_back('{64'h0000000000000001, 64'h3FE0000000000000, 2'd0, 64'h0000000000000000, 5'b00100, 4'b0011, 55});
      vq.push_back('{64'h0000000000000001, 64'h3FE0000000000000, 2'd2, 64'h0000000000000001, 5'b00010, 4'b0011, 55});
      vq.push_back('{64'h0008000000000000, 64'h4000000000000000, 2'd0, 64'h0010000000000000, 5'b00001, 4'b0000, 55});
`endif
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      rm = 2'd0;
      repeat (3) @(posedge clk);
      #1 chk("reset.hs", 80'({in_ready, out_valid}), 80'(2'b10));
      chk("reset.p", 80'(p), 80'(0));
      chk("reset.class", 80'({nan, inf, zero, dnorm, norm}), 80'(5'b00100));
      chk("reset.flags", 80'({invalid, overflow, underflow, inexact}), 80'(4'b0000));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      foreach (vq[i]) run(i, vq[i]);

      out_ready = 1'b0;
      a = 64'h3FF8000000000000;
      b = 64'h4000000000000000;
      rm = 2'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk("bp.latency", 80'(n), 80'(55));
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 chk($sformatf("bp.hold%0d", i), {10'd0, out_valid, in_ready, norm, invalid, overflow, underflow, inexact, p},
                {10'd0, 7'b1010000, 64'h4008000000000000});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp.release", 80'({out_valid, in_ready}), 80'(2'b01));

      a = 64'h3FF8000000000000;
      b = 64'h4000000000000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst.state", 80'({in_ready, out_valid, zero, p}), {13'd0, 3'b101, 64'd0});
      stale = 0;
      repeat (70) begin
         @(posedge clk);
         #1 if (out_valid) stale++;
      end
      chk("rst.stale", 80'(stale), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Sequential, parametrised IEEE-754 binary floating-point multiplier; successor to the combinational fp_mul.
- Adds clocked valid/ready handshakes, an iterative shift-add significand multiplier, four rounding modes and IEEE exception flags.
- Keeps the same five-way result classification outputs.
- Sits between the FPU operand register file and the result/writeback queue.

Parameters:
- NEXP, 11, exponent field width (>=3)
- NSIG, 52, stored significand width, hidden bit excluded (>=2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  NEXP+NSIG+1  operand A {sign, exp, sig}
- b  in  NEXP+NSIG+1  operand B
- rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf); sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- p  out  NEXP+NSIG+1  product
- nan, inf, zero, dnorm, norm  out  1 each  one-hot class of p
- invalid, overflow, underflow, inexact  out  1 each  IEEE exception flags for p

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: state=IDLE; in_ready=1; out_valid=0; p=0; zero=1; all other class bits and flags 0.
- Reset mid-operation abandons the operation; no out_valid pulse follows.
- States: IDLE, UNPK, MUL, RND, DONE.
- IDLE: in_ready=1. in_valid&&in_ready at edge k latches a, b, rm and moves to UNPK. in_ready=0 in every other state.
- UNPK (1 cycle): classify operands, form sign = sa^sb and biased exponent sum.
  - Any operand NaN, or inf*0: go to DONE with canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1 only for inf*0 or a signalling-NaN input.
  - inf*finite-nonzero: go to DONE with signed inf.
  - Zero*finite: go to DONE with signed zero.
  - Otherwise go to MUL.
- Special-case latency: out_valid high after edge k+2.
- MUL: shift-add, one multiplier bit per cycle, exactly NSIG+1 cycles. Produces a 2*(NSIG+1)-bit significand product.
- RND (1 cycle):
  - Normalise: 1-bit shift on product overflow; left shift for subnormal inputs.
  - Denormalise: right shift when the exponent falls below 1.
  - Round with guard/sticky per rm.
  - Round-up carry-out increments the exponent.
  - Exponent >= all-ones: overflow=inexact=1; result is inf (RNE, and the directed mode toward the sign) or max-finite (RTZ, and the directed mode away from the sign).
  - underflow=1 iff the result is tiny after rounding and inexact.
- Normal-path latency: out_valid high after edge k+NSIG+3 (55 for doubles).
- DONE: out_valid=1; p, class bits and flags stable. On out_ready, go to IDLE and drop out_valid on the next edge. out_ready held low stalls indefinitely with outputs held.
- Subnormal inputs: implicit bit 0, effective exponent 1.
- Class bits are exactly one-hot whenever out_valid=1. Outside DONE they hold their previous values.
- Zero exact result sign = sa^sb in all modes.

Optional Feature:
- Macro FP_MUL_FTZ_EN.
- Defined: subnormal inputs are treated as signed zero. Any result tiny before rounding becomes signed zero, with underflow=inexact=1. dnorm is never asserted.
- Undefined: gradual underflow as described in Behaviour.

Test Plan:
- 0x3FF8000000000000 * 0x4000000000000000, rm=00 -> p=0x4008000000000000, norm=1, all flags 0, out_valid exactly 55 cycles after accept.
- 0x7FF0000000000000 * 0x0000000000000000 -> p=0x7FF8000000000000, nan=1, invalid=1, out_valid 2 cycles after accept.
- 0x7FEFFFFFFFFFFFFF * 0x4000000000000000:
  - rm=00 -> 0x7FF0000000000000, inf=1, overflow=inexact=1.
  - rm=01 -> 0x7FEFFFFFFFFFFFFF, norm=1.
- 0x0010000000000000 * 0x3FE0000000000000, rm=00:
  - FTZ undefined -> 0x0008000000000000, dnorm=1, underflow=0.
  - FTZ_EN defined -> 0x0000000000000000, zero=1, underflow=inexact=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> p/flags held, in_ready=0 throughout. Release -> in_ready=1 the cycle after handshake.
- Assert rst_n=0 in MUL cycle 10 for one edge -> next cycle in_ready=1, out_valid=0, zero=1; no stale result ever appears.
